// File: rtl/fft_result_collector.sv
// fft_result_collector: deserialises tiny_fft output words into frames and replays them on a valid/ready stream
module fft_result_collector #(
  parameter int NUM_BINS = 8,
  parameter int WORD_W = 6,
  parameter int IDX_W = $clog2(NUM_BINS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               fft_io_out,
  input  logic                     cap_en,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [WORD_W-1:0] m_real,
  output logic signed [WORD_W-1:0] m_imag,
  output logic [IDX_W-1:0]         m_idx,
  output logic                     m_last,
  output logic                     sync_err,
  output logic                     overrun,
  output logic [7:0]               frame_cnt
);
  typedef enum logic [1:0] {HUNT, CAP_IM, CAP_RE} state_t;
  state_t state_q;
  logic [IDX_W-1:0] bin_q, rd_idx_q;
  logic signed [WORD_W-1:0] stg_re_q [NUM_BINS];
  logic signed [WORD_W-1:0] stg_im_q [NUM_BINS];
  logic signed [WORD_W-1:0] buf_re_q [2][NUM_BINS];
  logic signed [WORD_W-1:0] buf_im_q [2][NUM_BINS];
  logic [1:0] full_q, full_d;
  logic wr_q, rd_q, sync_err_q, overrun_q;
  logic [7:0] frame_cnt_q;
  logic signed [WORD_W-1:0] word;
  logic is_re, is_zero, start, ok, commit, beat, freed, room;
  assign word = fft_io_out[7 -: WORD_W];
  assign is_re = fft_io_out[1];
  assign is_zero = fft_io_out[0];
  assign start = is_zero & is_re & cap_en;
  assign ok = (state_q == CAP_IM) ? (!is_re & !is_zero) : (is_re & !is_zero);
  assign commit = (state_q == CAP_IM) && ok && (bin_q == IDX_W'(NUM_BINS - 1));
  assign beat = m_valid & m_ready;
  assign freed = beat & m_last;
  // a buffer finishing its last beat this cycle can take the committing frame
  assign room = !full_q[wr_q] | (freed & (rd_q == wr_q));
  always_comb begin
    full_d = full_q;
    if (freed) full_d[rd_q] = 1'b0;
    if (commit && room) full_d[wr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      bin_q <= '0;
      rd_idx_q <= '0;
      full_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      sync_err_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full_q <= full_d;
      sync_err_q <= 1'b0;
      if (beat) begin
        rd_idx_q <= rd_idx_q + 1'b1;
        if (m_last) rd_q <= ~rd_q;
      end
      if (commit && room) begin
        wr_q <= ~wr_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        for (int i = 0; i < NUM_BINS; i++) begin
          buf_re_q[wr_q][i] <= stg_re_q[i];
          buf_im_q[wr_q][i] <= (i == NUM_BINS - 1) ? word : stg_im_q[i];
        end
      end else if (commit) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        HUNT: if (start) begin
          stg_re_q[0] <= word;
          bin_q <= '0;
          state_q <= CAP_IM;
        end
        CAP_IM, CAP_RE: if (ok && state_q == CAP_IM) begin
          stg_im_q[bin_q] <= word;
          bin_q <= bin_q + 1'b1;
          state_q <= commit ? HUNT : CAP_RE;
        end else if (ok) begin
          stg_re_q[bin_q] <= word;
          state_q <= CAP_IM;
        end else begin
          sync_err_q <= 1'b1;
          bin_q <= '0;
          state_q <= start ? CAP_IM : HUNT;
          if (start) stg_re_q[0] <= word;
        end
        default: state_q <= HUNT;
      endcase
    end
  end
  assign m_valid = full_q[rd_q];
  assign m_real = m_valid ? buf_re_q[rd_q][rd_idx_q] : '0;
  assign m_imag = m_valid ? buf_im_q[rd_q][rd_idx_q] : '0;
  assign m_idx = rd_idx_q;
  assign m_last = m_valid & (rd_idx_q == IDX_W'(NUM_BINS - 1));
  assign sync_err = sync_err_q;
  assign overrun = overrun_q;
  assign frame_cnt = frame_cnt_q;
endmodule
